enc8_3_rr: RTL and testbench

Registered round-robin 8-to-3 encoder: the inverse path of the `mux3_8` 3-to-8 decoder. It takes eight level-sensitive request lines and returns the 3-bit index of one set line. A rotating priority pointer ensures every asserted line is eventually served. The output is held stable under a valid/ready handshake, so downstream logic, or a `mux3_8` re-decoding the index, sees one index per transfer.

---
 rtl/enc_pkg.sv | 21 ++
 rtl/rr_pick.sv | 30 +++
 rtl/enc8_3_rr.sv | 75 +++++++
 tb/tb_enc8_3_rr.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants, FSM states and helpers for the round-robin 8-to-3 encoder.
package enc_pkg;

    localparam int ENC_N     = 8;
    localparam int ENC_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } enc_state_t;

    function automatic logic [3:0] popcnt8(input logic [ENC_N-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < ENC_N; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-set-bit search starting at base: rotate, fixed-priority encode, un-rotate.
module rr_pick
    import enc_pkg::*;
(
    input  logic [ENC_N-1:0]     req,
    input  logic [ENC_IDX_W-1:0] base,
    output logic [ENC_IDX_W-1:0] idx
);

    logic [ENC_N-1:0]     w_rot;
    logic [ENC_IDX_W-1:0] w_enc;

    // w_rot[0] is the line at base, so the lowest set bit is the nearest upward.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < ENC_N; i++) begin
            w_rot[i] = req[3'(i) + base];
        end
    end

    always_comb begin
        w_enc = '0;
        for (int i = ENC_N - 1; i >= 0; i--) begin
            if (w_rot[i]) w_enc = 3'(i);
        end
    end

    assign idx = w_enc + base;

endmodule

// File: rtl/enc8_3_rr.sv
// Registered round-robin 8-to-3 encoder; index held under a valid/ready handshake.
module enc8_3_rr
    import enc_pkg::*;
#(
    parameter int N     = ENC_N,
    parameter int IDX_W = ENC_IDX_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [N-1:0]     Y_8,
    output logic [IDX_W-1:0] A_3,
    output logic             a_valid,
    input  logic             a_ready,
    output logic             multi_hot
);

    enc_state_t       r_state, w_nxt_state;
    logic [IDX_W-1:0] r_ptr, r_a, w_base, w_idx, w_a_inc;
    logic             r_vld, r_mh, w_load, w_hs, w_any;

    assign w_any   = |Y_8;
    assign w_a_inc = r_a + 3'd1;
    assign w_hs    = (r_state == OFFER) && a_ready;
    // A reload on handshake picks from just past the granted line, not the stale ptr.
    assign w_base  = (r_state == OFFER) ? w_a_inc : r_ptr;

    rr_pick u_pick (
        .req  (Y_8),
        .base (w_base),
        .idx  (w_idx)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_nxt_state = OFFER;
                end
            end
            OFFER: begin
                if (a_ready) begin
                    if (w_any) w_load = 1'b1;
                    else       w_nxt_state = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_a     <= '0;
            r_vld   <= 1'b0;
            r_mh    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_vld   <= (w_nxt_state == OFFER);
            if (w_hs) r_ptr <= w_a_inc;
            if (w_load) begin
                r_a  <= w_idx;
                r_mh <= (popcnt8(Y_8) > 4'd1);
            end
        end
    end

    assign A_3       = r_a;
    assign a_valid   = r_vld;
    assign multi_hot = r_mh;

endmodule

// File: tb/tb_enc8_3_rr.sv
// Directed self-checking bench for enc8_3_rr with hand-computed expected grants.
module tb_enc8_3_rr;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] Y_8;
    logic [2:0] A_3;
    logic       a_valid;
    logic       a_ready;
    logic       multi_hot;

    int total = 0;
    int bad   = 0;

    enc8_3_rr dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .Y_8       (Y_8),
        .A_3       (A_3),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .multi_hot (multi_hot)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic out3(input string tag, input logic [2:0] a, input logic v, input logic m);
        chk({tag, ".A"}, {5'd0, A_3}, {5'd0, a});
        chk({tag, ".V"}, {7'd0, a_valid}, {7'd0, v});
        chk({tag, ".M"}, {7'd0, multi_hot}, {7'd0, m});
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        Y_8       = 8'h00;
        a_ready   = 1'b0;
        step();
        step();
        sys_rst_n = 1'b1;
    endtask

    initial begin
        sys_rst_n = 1'b1;
        Y_8       = 8'h00;
        a_ready   = 1'b1;
        #1;

        // Reset with all lines requesting
        sys_rst_n = 1'b0;
        Y_8       = 8'hFF;
        #1;
        out3("rst0", 3'd0, 1'b0, 1'b0);
        step();
        out3("rst1", 3'd0, 1'b0, 1'b0);
        step();
        out3("rst2", 3'd0, 1'b0, 1'b0);
        sys_rst_n = 1'b1;
        step();
        out3("rst_first", 3'd0, 1'b1, 1'b1);

        // One-hot sweep
        do_reset();
        a_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Y_8 = 8'h01 << i;
            step();
            out3($sformatf("hot%0d", i), 3'(i), 1'b1, 1'b0);
        end
        Y_8 = 8'h00;
        step();
        chk("hot_drop.V", {7'd0, a_valid}, 8'd0);

        // Round-robin with wrap: 2,6,2,6
        do_reset();
        a_ready = 1'b1;
        Y_8     = 8'b0100_0100;
        step(); out3("rr0", 3'd2, 1'b1, 1'b1);
        step(); out3("rr1", 3'd6, 1'b1, 1'b1);
        step(); out3("rr2", 3'd2, 1'b1, 1'b1);
        step(); out3("rr3", 3'd6, 1'b1, 1'b1);

        // Stall hold
        do_reset();
        a_ready = 1'b0;
        Y_8     = 8'h20;
        step(); out3("st_grant", 3'd5, 1'b1, 1'b0);
        Y_8 = 8'h01;
        step(); out3("st1", 3'd5, 1'b1, 1'b0);
        step(); out3("st2", 3'd5, 1'b1, 1'b0);
        Y_8 = 8'h00;
        step(); out3("st3", 3'd5, 1'b1, 1'b0);
        step(); out3("st4", 3'd5, 1'b1, 1'b0);
        a_ready = 1'b1;
        Y_8     = 8'h01;
        step(); out3("st_next", 3'd0, 1'b1, 1'b0);

        // Back-to-back on a single line, then drop during a handshake
        do_reset();
        a_ready = 1'b1;
        Y_8     = 8'h80;
        for (int i = 0; i < 4; i++) begin
            step();
            out3($sformatf("b2b%0d", i), 3'd7, 1'b1, 1'b0);
        end
        Y_8 = 8'h00;
        step();
        chk("b2b_drop.V", {7'd0, a_valid}, 8'd0);

        // Asynchronous reset while offering index 3
        do_reset();
        a_ready = 1'b0;
        Y_8     = 8'h08;
        step(); out3("mid_grant", 3'd3, 1'b1, 1'b0);
        Y_8 = 8'h18;
        #2;
        sys_rst_n = 1'b0;
        #1;
        out3("mid_async", 3'd0, 1'b0, 1'b0);
        step();
        out3("mid_hold", 3'd0, 1'b0, 1'b0);
        sys_rst_n = 1'b1;
        a_ready   = 1'b1;
        step();
        out3("mid_after", 3'd3, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
